// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB device endpoints: FSM encoding, packet limits
// and an elaboration-time clog2 helper.
package usb_ep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE,
    ST_WAIT_ACK
  } ep_state_t;

  localparam int USB_FS_MAX_BULK_PKT = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_bulk_in_ep_if.sv
// IN-endpoint link between the endpoint (master, writer) and the protocol engine (slave).
interface usb_bulk_in_ep_if;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked;

  modport master (
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    input  in_ep_grant, in_ep_data_free, in_ep_acked
  );

  modport slave (
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    output in_ep_grant, in_ep_data_free, in_ep_acked
  );
endinterface

// File: rtl/usb_ep_fifo.sv
// Synchronous first-word-fall-through FIFO; push when full and pop when empty are ignored.
module usb_ep_fifo
  import usb_ep_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_level
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/usb_bulk_in_ep.sv
// Bulk IN endpoint: buffers user bytes and hands them to the protocol engine
// as packets of up to MAX_PKT bytes, one packet in flight until the host ACKs.
//
//   state       | meaning
//   IDLE        | waiting for a send trigger (level, timeout, flush, owed ZLP)
//   REQ         | requesting the IN arbiter, waiting for grant && data_free
//   FILL        | streaming pkt_len bytes from the FIFO head
//   DONE        | one-cycle packet-complete strobe, zlp_owed update
//   WAIT_ACK    | packet handed off, waiting for the host ACK
module usb_bulk_in_ep
  import usb_ep_pkg::*;
#(
  parameter int MAX_PKT    = USB_FS_MAX_BULK_PKT,
  parameter int FIFO_DEPTH = 128,
  parameter int TIMEOUT    = 4800
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_en,
  output logic                        wr_full,
  output logic [clog2(FIFO_DEPTH):0]  wr_level,
  output logic                        overflow,
  input  logic                        flush,
  input  logic                        halt,
  output logic                        busy,
  usb_bulk_in_ep_if.master            ep
);
  localparam int LW = clog2(FIFO_DEPTH) + 1;
  localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] MAX_LVL = LW'(MAX_PKT);
  localparam logic [6:0]    MAX_LEN = 7'(MAX_PKT);
  localparam logic [TW-1:0] TO_VAL  = TW'(TIMEOUT);

  ep_state_t     r_state;
  logic [6:0]    r_pkt_len;
  logic [6:0]    r_byte_cnt;
  logic          r_zlp_owed;
  logic          r_flush_pend;
  logic          r_req;
  logic          r_done;
  logic          r_busy;
  logic          r_stall;
  logic          r_overflow;
  logic [TW-1:0] r_to_cnt;

  logic [LW-1:0] w_level;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_put;
  logic          w_go;
  logic          w_flush;
  logic          w_to_hit;
  logic          w_trigger;
  logic [6:0]    w_len;

  usb_ep_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (wr_en),
    .i_data  (wr_data),
    .i_pop   (w_put),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_go      = ep.in_ep_grant && ep.in_ep_data_free;
  // byte_cnt < pkt_len <= level-at-latch guarantees the FIFO is never popped empty.
  assign w_put     = (r_state == ST_FILL) && w_go && (r_byte_cnt < r_pkt_len);
  assign w_flush   = flush || r_flush_pend;
  assign w_to_hit  = (TIMEOUT != 0) && (r_to_cnt == TO_VAL);
  assign w_trigger = !halt && ((w_level >= MAX_LVL) || (!w_empty && (w_to_hit || w_flush))
                               || (w_flush && r_zlp_owed));
  assign w_len     = (w_level >= MAX_LVL) ? MAX_LEN : 7'(w_level);

  assign wr_full            = w_full;
  assign wr_level           = w_level;
  assign overflow           = r_overflow;
  assign busy               = r_busy;
  assign ep.in_ep_req       = r_req;
  assign ep.in_ep_data_put  = w_put;
  assign ep.in_ep_data      = w_empty ? 8'h00 : w_head;
  assign ep.in_ep_data_done = r_done;
  assign ep.in_ep_stall     = r_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt   <= '0;
      r_overflow <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_overflow <= wr_en && w_full;
      r_stall    <= halt;
      if ((wr_en && !w_full) || w_empty) r_to_cnt <= '0;
      else if (r_to_cnt != TO_VAL)       r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pkt_len    <= '0;
      r_byte_cnt   <= '0;
      r_zlp_owed   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_req        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && flush) r_flush_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_pkt_len    <= w_len;
            r_byte_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_req        <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_REQ;
          end else begin
            // A flush seen while halted waits for the halt to clear.
            r_flush_pend <= halt && w_flush;
          end
        end
        ST_REQ: begin
          if (w_go) begin
            if (r_pkt_len == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (w_put) begin
            r_byte_cnt <= r_byte_cnt + 7'd1;
            if ((r_byte_cnt + 7'd1) == r_pkt_len) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_zlp_owed <= (r_pkt_len == MAX_LEN);
          r_req      <= 1'b0;
          r_state    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ep.in_ep_acked) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
